// File: rtl/multiword_adder_sequencer.sv
// Serial multi-word adder: one ripple slice reused ADDER_WIDTH bits per cycle, LSW first.
// Optional subtract/overflow support is enabled by defining ARITH_SUB_EN.
module ripple_carry_adder_Nb #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         ci_i,
  output logic [N-1:0] s_o,
  output logic         co_o
);
  logic c;

  always_comb begin
    c   = ci_i;
    s_o = '0;
    for (int i = 0; i < N; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    co_o = c;
  end
endmodule

module multiword_adder_sequencer #(
  parameter int ADDER_WIDTH = 4,
  parameter int NUM_WORDS   = 4
) (
  input  logic                             iClk,
  input  logic                             iRst,
  input  logic                             iStart,
  input  logic [ADDER_WIDTH*NUM_WORDS-1:0] iA,
  input  logic [ADDER_WIDTH*NUM_WORDS-1:0] iB,
  input  logic                             iCarry,
`ifdef ARITH_SUB_EN
  input  logic                             iSub,
  output logic                             oOvf,
`endif
  output logic                             oReady,
  output logic                             oBusy,
  output logic                             oDone,
  output logic [ADDER_WIDTH*NUM_WORDS-1:0] oSum,
  output logic                             oCarry
);
  localparam int AW = ADDER_WIDTH;
  localparam int W  = ADDER_WIDTH * NUM_WORDS;
  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           sub_w;
  logic [31:0]    base_w;
  logic [AW-1:0]  a_sl, b_sl, sum_sl;
  logic           co_sl;

`ifdef ARITH_SUB_EN
  logic ovf_q, ovf_d;
  assign sub_w = iSub;
  assign oOvf  = ovf_q;
`else
  assign sub_w = 1'b0;
`endif

  assign base_w = 32'(cnt_q) * 32'(AW);
  assign a_sl   = a_q[base_w +: AW];
  assign b_sl   = b_q[base_w +: AW];

  ripple_carry_adder_Nb #(
    .N (AW)
  ) u_slice (
    .a_i  (a_sl),
    .b_i  (b_sl),
    .ci_i (carry_q),
    .s_o  (sum_sl),
    .co_o (co_sl)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef ARITH_SUB_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          a_d     = iA;
          b_d     = sub_w ? ~iB : iB;
          carry_d = sub_w ? 1'b1 : iCarry;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base_w +: AW] = sum_sl;
        carry_d             = co_sl;
        if (cnt_q == LAST) begin
          cout_d  = co_sl;
`ifdef ARITH_SUB_EN
          // Signed overflow: equal operand signs but result sign differs
          ovf_d   = (a_sl[AW-1] == b_sl[AW-1]) &&
                    (sum_sl[AW-1] != a_sl[AW-1]);
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ARITH_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef ARITH_SUB_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign oReady = (state_q == IDLE);
  assign oBusy  = (state_q == RUN);
  assign oDone  = (state_q == DONE);
  assign oSum   = sum_q;
  assign oCarry = cout_q;
endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// Scoreboard bench for multiword_adder_sequencer (AW=4, N=4).
// Define ARITH_SUB_EN to also exercise subtract and overflow.
module tb_multiword_adder_sequencer;
  localparam int AW = 4;
  localparam int N  = 4;
  localparam int W  = AW * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         ci;
  logic         rdy, busy, done, co;
  logic [W-1:0] sum;
  logic         sub;
`ifdef ARITH_SUB_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  multiword_adder_sequencer #(
    .ADDER_WIDTH (AW),
    .NUM_WORDS   (N)
  ) dut (
    .iClk   (clk),
    .iRst   (rst),
    .iStart (start),
    .iA     (a),
    .iB     (b),
    .iCarry (ci),
`ifdef ARITH_SUB_EN
    .iSub   (sub),
    .oOvf   (ovf),
`endif
    .oReady (rdy),
    .oBusy  (busy),
    .oDone  (done),
    .oSum   (sum),
    .oCarry (co)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every oDone pulse must match the oldest outstanding op
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("carry", 32'(co), 32'(e.c));
        chk("latency_cycle", cyc, e.cyc);
`ifdef ARITH_SUB_EN
        chk("ovf", 32'(ovf), 32'(e.v));
`endif
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic [W-1:0] es,
                       input logic ec, input logic ev, input bit push);
    int n;
    n = 0;
    while (!rdy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_before_start", 32'(rdy), 32'd1);
    a     = ia;
    b     = ib;
    ci    = ic;
    start = 1'b1;
    if (push) q.push_back('{es, ec, ev, cyc + N + 1});
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~ia;
    b     = ~ib;
    ci    = ~ic;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    ci    = 1'b0;
    sub   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 32'(rdy), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(co), 32'd0);
    @(posedge clk);
    #1;
    chk("idle_ready", 32'(rdy), 32'd1);

    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("run_busy", 32'(busy), 32'd1);
    issue(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b1);

    issue(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    chk("busy_start_ready", 32'(rdy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;

    issue(16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("midrst_ready", 32'(rdy), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_carry", 32'(co), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_stay_idle", 32'(rdy), 32'd1);
    issue(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1);

`ifdef ARITH_SUB_EN
    sub = 1'b1;
    issue(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    issue(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    sub = 1'b0;
`endif

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
`ifdef ARITH_SUB_EN
    chk("idle_hold_sum", 32'(sum), 32'h7FFF);
`else
    chk("idle_hold_sum", 32'(sum), 32'h0007);
`endif
    chk("idle_ready_end", 32'(rdy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
